sync_fifo_asymm_fwft: RTL and testbench

Single-clock, first-word-fall-through (FWFT) FIFO that converts between unequal write and read widths.
- Conversion direction is inferred from parameters: narrow-to-wide (concat), wide-to-narrow (split), or equal (plain FIFO).
- Generalises the async concat/split pair with arbitrary power-of-2 ratios in either direction and partial-word flush for concat.
- Adds framing outputs (rd_keep, rd_last) and an occupancy level.
- Used in same-clock datapaths where the async variants waste synchroniser latency.

---
 rtl/sync_fifo_asymm_fwft.sv | 171 +++++++++++++++++
 tb/tb_sync_fifo_asymm_fwft.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_asymm_fwft.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : sync_fifo_asymm_fwft
// Purpose  : Single-clock FWFT FIFO converting between unequal write/read
//            widths (narrow->wide concat, wide->narrow split, or equal).
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_asymm_fwft #(
    parameter int WR_WIDTH_BYTES = 1,
    parameter int RD_WIDTH_BYTES = 4,
    parameter int ADDR_WIDTH     = 4,
    parameter int RESERVE        = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [8*WR_WIDTH_BYTES-1:0] wr_data,
    input  logic                        wr_last,
    output logic                        full,
    input  logic                        rd_en,
    output logic [8*RD_WIDTH_BYTES-1:0] rd_data,
    output logic [RD_WIDTH_BYTES-1:0]   rd_keep,
    output logic                        rd_last,
    output logic                        empty,
    output logic                        has_data,
    output logic [ADDR_WIDTH:0]         level
);

    localparam int c_DEPTH        = 2 ** ADDR_WIDTH;
    localparam int c_WIDE_BYTES   = (WR_WIDTH_BYTES > RD_WIDTH_BYTES) ? WR_WIDTH_BYTES : RD_WIDTH_BYTES;
    localparam int c_NARROW_BYTES = (WR_WIDTH_BYTES > RD_WIDTH_BYTES) ? RD_WIDTH_BYTES : WR_WIDTH_BYTES;
    localparam int c_RATIO        = c_WIDE_BYTES / c_NARROW_BYTES;
    localparam bit c_IS_CONCAT    = RD_WIDTH_BYTES > WR_WIDTH_BYTES;
    localparam bit c_IS_SPLIT     = WR_WIDTH_BYTES > RD_WIDTH_BYTES;
    localparam int c_WR_W         = 8 * WR_WIDTH_BYTES;
    localparam int c_RD_W         = 8 * RD_WIDTH_BYTES;
    localparam int c_WIDE_W       = 8 * c_WIDE_BYTES;
    localparam int c_LANES        = c_WIDE_W / c_WR_W;
    localparam int c_SLICES       = c_WIDE_W / c_RD_W;
    localparam int c_IDX_W        = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;

    localparam logic [c_IDX_W-1:0]  c_LANE_LAST  = c_IDX_W'(c_LANES - 1);
    localparam logic [c_IDX_W-1:0]  c_SLICE_LAST = c_IDX_W'(c_SLICES - 1);
    localparam logic [ADDR_WIDTH:0] c_DEPTH_L    = (ADDR_WIDTH + 1)'(c_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_RESERVE_L  = (ADDR_WIDTH + 1)'(RESERVE);

    generate
        if ((WR_WIDTH_BYTES < 1) || (RD_WIDTH_BYTES < 1) ||
            ((c_WIDE_BYTES % c_NARROW_BYTES) != 0) || (c_RATIO > 16) ||
            ((c_RATIO & (c_RATIO - 1)) != 0)) begin : g_bad_ratio
            $error("sync_fifo_asymm_fwft: width ratio must be a power of 2 in 1..16");
        end
        if ((RESERVE < 0) || (RESERVE >= c_DEPTH)) begin : g_bad_reserve
            $error("sync_fifo_asymm_fwft: RESERVE must be in 0..DEPTH-1");
        end
    endgenerate

    // Storage is written only on commit; level alone decides validity, so no reset.
    logic [c_WIDE_W-1:0]       mem_data_q [c_DEPTH];
    logic [RD_WIDTH_BYTES-1:0] mem_keep_q [c_DEPTH];
    logic [c_DEPTH-1:0]        mem_last_q;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [c_IDX_W-1:0]    pack_idx_q, pack_idx_d;
    logic [c_IDX_W-1:0]    unpack_idx_q, unpack_idx_d;
    logic [c_WIDE_W-1:0]   pack_data_q, pack_data_d;

    logic                      w_wr_accept;
    logic                      w_rd_accept;
    logic                      w_commit;
    logic                      w_pop;
    logic [c_WIDE_W-1:0]       w_pack_next;
    logic [RD_WIDTH_BYTES-1:0] w_commit_keep;
    logic [c_WIDE_W-1:0]       w_head_data;

    always_comb begin
        full     = (c_DEPTH_L - level_q) <= c_RESERVE_L;
        empty    = (level_q == '0);
        has_data = !empty;
        level    = level_q;

        w_wr_accept = wr_en && !full;
        w_rd_accept = rd_en && !empty;

        // Split and equal modes have a single lane, so every write commits.
        w_pack_next = pack_data_q;
        for (int i = 0; i < c_LANES; i++) begin
            if (c_IDX_W'(i) == pack_idx_q) begin
                w_pack_next[i*c_WR_W +: c_WR_W] = wr_data;
            end
        end
        w_commit = w_wr_accept && ((pack_idx_q == c_LANE_LAST) || (c_IS_CONCAT && wr_last));

        for (int b = 0; b < RD_WIDTH_BYTES; b++) begin
            w_commit_keep[b] = ((b / WR_WIDTH_BYTES) <= int'(pack_idx_q));
        end

        w_pop = w_rd_accept && (unpack_idx_q == c_SLICE_LAST);

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        pack_idx_d   = pack_idx_q;
        pack_data_d  = pack_data_q;
        unpack_idx_d = unpack_idx_q;

        if (w_wr_accept) begin
            if (w_commit) begin
                pack_idx_d  = '0;
                pack_data_d = '0;
                wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(1);
            end else begin
                pack_idx_d  = pack_idx_q + c_IDX_W'(1);
                pack_data_d = w_pack_next;
            end
        end

        if (w_rd_accept) begin
            if (w_pop) begin
                unpack_idx_d = '0;
                rd_ptr_d     = rd_ptr_q + ADDR_WIDTH'(1);
            end else begin
                unpack_idx_d = unpack_idx_q + c_IDX_W'(1);
            end
        end

        level_d = level_q + (ADDR_WIDTH + 1)'(w_commit) - (ADDR_WIDTH + 1)'(w_pop);
    end

    always_comb begin
        w_head_data = mem_data_q[rd_ptr_q];
        rd_data     = '0;
        for (int s = 0; s < c_SLICES; s++) begin
            if (c_IDX_W'(s) == unpack_idx_q) begin
                rd_data = w_head_data[s*c_RD_W +: c_RD_W];
            end
        end
        rd_keep = empty ? '0 : mem_keep_q[rd_ptr_q];
        rd_last = !empty && (c_IS_SPLIT ? (unpack_idx_q == c_SLICE_LAST) : mem_last_q[rd_ptr_q]);
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            mem_data_q[wr_ptr_q] <= w_pack_next;
            mem_keep_q[wr_ptr_q] <= w_commit_keep;
            mem_last_q[wr_ptr_q] <= c_IS_CONCAT ? wr_last : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            pack_idx_q   <= '0;
            pack_data_q  <= '0;
            unpack_idx_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            pack_idx_q   <= pack_idx_d;
            pack_data_q  <= pack_data_d;
            unpack_idx_q <= unpack_idx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_asymm_fwft.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_asymm_fwft
// Purpose  : Bench for concat (1->4), split (4->1) and equal-width instances
//            against queue-based reference models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_asymm_fwft;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // ---------------- concat 1 -> 4, depth 8 ----------------
    logic        c_rst = 1'b1, c_wr_en = 1'b0, c_wr_last = 1'b0, c_rd_en = 1'b0;
    logic [7:0]  c_wr_data = '0;
    logic [31:0] c_rd_data;
    logic [3:0]  c_rd_keep, c_level;
    logic        c_rd_last, c_full, c_empty, c_has_data;

    sync_fifo_asymm_fwft #(.WR_WIDTH_BYTES(1), .RD_WIDTH_BYTES(4), .ADDR_WIDTH(3), .RESERVE(0)) u_cat (
        .clk(clk), .rst(c_rst), .wr_en(c_wr_en), .wr_data(c_wr_data), .wr_last(c_wr_last),
        .full(c_full), .rd_en(c_rd_en), .rd_data(c_rd_data), .rd_keep(c_rd_keep),
        .rd_last(c_rd_last), .empty(c_empty), .has_data(c_has_data), .level(c_level)
    );

    // ---------------- split 4 -> 1, depth 8 ----------------
    logic        s_rst = 1'b1, s_wr_en = 1'b0, s_wr_last = 1'b0, s_rd_en = 1'b0;
    logic [31:0] s_wr_data = '0;
    logic [7:0]  s_rd_data;
    logic [0:0]  s_rd_keep;
    logic [3:0]  s_level;
    logic        s_rd_last, s_full, s_empty, s_has_data;

    sync_fifo_asymm_fwft #(.WR_WIDTH_BYTES(4), .RD_WIDTH_BYTES(1), .ADDR_WIDTH(3), .RESERVE(0)) u_spl (
        .clk(clk), .rst(s_rst), .wr_en(s_wr_en), .wr_data(s_wr_data), .wr_last(s_wr_last),
        .full(s_full), .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_keep(s_rd_keep),
        .rd_last(s_rd_last), .empty(s_empty), .has_data(s_has_data), .level(s_level)
    );

    // ---------------- equal 1 -> 1, depth 4, reserve 1 ----------------
    logic        e_rst = 1'b1, e_wr_en = 1'b0, e_wr_last = 1'b0, e_rd_en = 1'b0;
    logic [7:0]  e_wr_data = '0;
    logic [7:0]  e_rd_data;
    logic [0:0]  e_rd_keep;
    logic [2:0]  e_level;
    logic        e_rd_last, e_full, e_empty, e_has_data;

    sync_fifo_asymm_fwft #(.WR_WIDTH_BYTES(1), .RD_WIDTH_BYTES(1), .ADDR_WIDTH(2), .RESERVE(1)) u_eq (
        .clk(clk), .rst(e_rst), .wr_en(e_wr_en), .wr_data(e_wr_data), .wr_last(e_wr_last),
        .full(e_full), .rd_en(e_rd_en), .rd_data(e_rd_data), .rd_keep(e_rd_keep),
        .rd_last(e_rd_last), .empty(e_empty), .has_data(e_has_data), .level(e_level)
    );

    // ---------------- reference models ----------------
    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } cat_ent_t;

    typedef struct {
        logic [7:0] b;
        logic       l;
    } byte_ent_t;

    cat_ent_t   cq[$];
    logic [7:0] cpend[$];
    byte_ent_t  sq[$];
    logic [7:0] eq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cat_check();
        chk("cat_empty", c_empty, cq.size() == 0);
        chk("cat_has_data", c_has_data, cq.size() != 0);
        chk("cat_level", c_level, cq.size());
        chk("cat_full", c_full, cq.size() >= 8);
        if (cq.size() != 0) begin
            chk("cat_data", c_rd_data, cq[0].d);
            chk("cat_keep", c_rd_keep, cq[0].k);
            chk("cat_last", c_rd_last, cq[0].l);
        end else begin
            chk("cat_keep_idle", c_rd_keep, 0);
            chk("cat_last_idle", c_rd_last, 0);
        end
    endtask

    task automatic cat_step(input logic we, input logic [7:0] d, input logic wl, input logic re);
        logic        wa, ra;
        logic [31:0] w;
        c_wr_en = we; c_wr_data = d; c_wr_last = wl; c_rd_en = re;
        wa = we && (cq.size() < 8);
        ra = re && (cq.size() != 0);
        @(posedge clk); #1;
        c_wr_en = 1'b0; c_wr_last = 1'b0; c_rd_en = 1'b0;
        if (ra) void'(cq.pop_front());
        if (wa) begin
            cpend.push_back(d);
            if (cpend.size() == 4 || wl) begin
                w = '0;
                for (int i = 0; i < cpend.size(); i++) w[i*8 +: 8] = cpend[i];
                cq.push_back('{d: w, k: 4'((1 << cpend.size()) - 1), l: wl});
                cpend.delete();
            end
        end
        cat_check();
    endtask

    function automatic int spl_level();
        return (sq.size() + 3) / 4;
    endfunction

    task automatic spl_check();
        chk("spl_empty", s_empty, sq.size() == 0);
        chk("spl_has_data", s_has_data, sq.size() != 0);
        chk("spl_level", s_level, spl_level());
        chk("spl_full", s_full, spl_level() >= 8);
        chk("spl_keep", s_rd_keep, sq.size() != 0);
        if (sq.size() != 0) begin
            chk("spl_data", s_rd_data, sq[0].b);
            chk("spl_last", s_rd_last, sq[0].l);
        end else begin
            chk("spl_last_idle", s_rd_last, 0);
        end
    endtask

    task automatic spl_step(input logic we, input logic [31:0] d, input logic re);
        logic wa, ra;
        s_wr_en = we; s_wr_data = d; s_wr_last = 1'($urandom); s_rd_en = re;
        wa = we && (spl_level() < 8);
        ra = re && (sq.size() != 0);
        @(posedge clk); #1;
        s_wr_en = 1'b0; s_rd_en = 1'b0;
        if (ra) void'(sq.pop_front());
        if (wa) for (int i = 0; i < 4; i++) sq.push_back('{b: d[i*8 +: 8], l: (i == 3)});
        spl_check();
    endtask

    task automatic eq_check();
        chk("eq_empty", e_empty, eq.size() == 0);
        chk("eq_level", e_level, eq.size());
        chk("eq_full", e_full, eq.size() >= 3);
        chk("eq_keep", e_rd_keep, eq.size() != 0);
        chk("eq_last", e_rd_last, eq.size() != 0);
        if (eq.size() != 0) chk("eq_data", e_rd_data, eq[0]);
    endtask

    task automatic eq_step(input logic we, input logic [7:0] d, input logic re);
        logic wa, ra;
        e_wr_en = we; e_wr_data = d; e_wr_last = 1'($urandom); e_rd_en = re;
        wa = we && (eq.size() < 3);
        ra = re && (eq.size() != 0);
        @(posedge clk); #1;
        e_wr_en = 1'b0; e_rd_en = 1'b0;
        if (ra) void'(eq.pop_front());
        if (wa) eq.push_back(d);
        eq_check();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        c_rst = 1'b0; s_rst = 1'b0; e_rst = 1'b0;
        cat_check();
        spl_check();
        eq_check();

        // Concat: three bytes stay invisible, the fourth commits (rd_en ignored while empty).
        cat_step(1, 8'hA0, 0, 0);
        cat_step(1, 8'hA1, 0, 0);
        cat_step(1, 8'hA2, 0, 0);
        chk("cat_partial_hidden", c_empty, 1);
        cat_step(1, 8'hA3, 0, 1);
        chk("cat_word_a", c_rd_data, 32'hA3A2A1A0);
        chk("cat_keep_a", c_rd_keep, 4'hF);
        cat_step(0, 8'h00, 0, 1);
        chk("cat_popped_level", c_level, 0);

        // Concat flush then a full word.
        cat_step(1, 8'h11, 0, 0);
        cat_step(1, 8'h22, 1, 0);
        chk("cat_flush_data", c_rd_data, 32'h0000_2211);
        chk("cat_flush_keep", c_rd_keep, 4'h3);
        chk("cat_flush_last", c_rd_last, 1);
        cat_step(1, 8'h33, 0, 1);
        cat_step(1, 8'h44, 0, 0);
        cat_step(1, 8'h55, 0, 0);
        cat_step(1, 8'h66, 0, 0);
        chk("cat_word_b", c_rd_data, 32'h6655_4433);
        cat_step(0, 8'h00, 0, 1);

        // Concat reset mid-stream: 3 words stored plus 2 bytes packed.
        for (int i = 0; i < 14; i++) cat_step(1, 8'(i + 8'h80), 0, 0);
        chk("cat_pre_reset_level", c_level, 3);
        c_rst = 1'b1;
        @(posedge clk); #1;
        c_rst = 1'b0;
        cq.delete();
        cpend.delete();
        cat_check();
        for (int i = 0; i < 4; i++) cat_step(1, 8'(8'hC0 + i), 0, 0);
        chk("cat_fresh_word", c_rd_data, 32'hC3C2C1C0);

        for (int i = 0; i < 250; i++)
            cat_step($urandom_range(0, 99) < 65, 8'($urandom), $urandom_range(0, 4) == 0,
                     $urandom_range(0, 99) < 45);

        // Split: LSB slice first, last only on the top byte.
        spl_step(1, 32'hDEADBEEF, 0);
        chk("spl_b0", s_rd_data, 8'hEF);
        spl_step(0, 0, 1);
        chk("spl_b1", s_rd_data, 8'hBE);
        spl_step(0, 0, 1);
        chk("spl_b2", s_rd_data, 8'hAD);
        spl_step(0, 0, 1);
        chk("spl_b3", s_rd_data, 8'hDE);
        chk("spl_b3_last", s_rd_last, 1);
        spl_step(0, 0, 1);
        chk("spl_drained", s_empty, 1);

        // Split interleave.
        spl_step(1, 32'h01020304, 0);
        spl_step(0, 0, 1);
        spl_step(0, 0, 1);
        spl_step(1, 32'h05060708, 0);
        chk("spl_il_level", s_level, 2);
        for (int i = 0; i < 6; i++) spl_step(0, 0, 1);
        chk("spl_il_level_end", s_level, 0);

        for (int i = 0; i < 250; i++)
            spl_step($urandom_range(0, 99) < 30, $urandom, $urandom_range(0, 99) < 70);

        // Equal widths with RESERVE=1 on a depth-4 store.
        eq_step(1, 8'h10, 0);
        eq_step(1, 8'h20, 0);
        eq_step(1, 8'h30, 0);
        chk("eq_full_at3", e_full, 1);
        eq_step(1, 8'h40, 0);
        chk("eq_level_hold", e_level, 3);
        eq_step(1, 8'h50, 1);
        chk("eq_level_pop", e_level, 2);
        chk("eq_head", e_rd_data, 8'h20);

        for (int i = 0; i < 200; i++)
            eq_step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
